// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: load access sizes, FSM states and
// the MEM/WB pipeline register layout.
package wb_pkg;

    // Widths the MEM/WB register layout is built for; the stage parameters
    // default to these and must be left at them.
    localparam int WB_XLEN       = 64;
    localparam int WB_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LS_BYTE   = 2'd0,
        LS_HALF   = 2'd1,
        LS_WORD   = 2'd2,
        LS_DOUBLE = 2'd3
    } load_size_e;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_WRITE      = 2'd1,
        WB_ECALL_WAIT = 2'd2
    } wb_state_e;

    // MEM/WB register. The writeback value is selected (ALU result or
    // extended load) at capture, so only the final value is kept.
    typedef struct packed {
        logic [WB_XLEN-1:0]       pc;
        logic [WB_XLEN-1:0]       wdata;
        logic [WB_REG_ADDR_W-1:0] dest_reg;
        logic                     reg_write;
    } mem_wb_t;

endpackage

// File: rtl/writeback_stage_load_extender.sv
// load_extender: selects the addressed lane of a raw doubleword and zero- or
// sign-extends it to XLEN. Purely combinational. Address bits below the
// access size are ignored, so misaligned accesses read the aligned lane.
module load_extender
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
) (
    input  logic [XLEN-1:0] raw_data,
    input  logic [2:0]      offset,
    input  load_size_e      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] word_lane;

    // Lane selection from the low address bits
    always_comb begin
        byte_lane = raw_data[{offset, 3'b000} +: 8];
        half_lane = raw_data[{offset[2:1], 4'b0000} +: 16];
        word_lane = raw_data[{offset[2], 5'b00000} +: 32];
    end

    // Extension by access size; a doubleword passes through unchanged
    always_comb begin
        result = raw_data;
        case (size)
            LS_BYTE: begin
                result = is_unsigned ? {{(XLEN-8){1'b0}}, byte_lane}
                                     : {{(XLEN-8){byte_lane[7]}}, byte_lane};
            end
            LS_HALF: begin
                result = is_unsigned ? {{(XLEN-16){1'b0}}, half_lane}
                                     : {{(XLEN-16){half_lane[15]}}, half_lane};
            end
            LS_WORD: begin
                result = is_unsigned ? {{(XLEN-32){1'b0}}, word_lane}
                                     : {{(XLEN-32){word_lane[31]}}, word_lane};
            end
            default: result = raw_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Captures one completed instruction
// per mem_done pulse, writes the register file one cycle later, and holds
// ecalls until the environment acknowledges them with ecall_done.
// Optional build macro WB_RETIRE_COUNT_EN adds the instret retire counter.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_done,
    input  logic [XLEN-1:0]       mem_pc,
    input  logic [XLEN-1:0]       mem_alu_data,
    input  logic [XLEN-1:0]       mem_load_data,
    input  logic [REG_ADDR_W-1:0] mem_dest_reg,
    input  logic                  mem_reg_write,
    input  logic                  mem_is_load,
    input  logic [1:0]            mem_load_size,
    input  logic                  mem_load_unsigned,
    input  logic                  mem_is_ecall,
    input  logic                  ecall_done,
    output logic                  mem_wb_pipeline_valid,
    output logic                  ecall_req,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  retired,
    output logic [XLEN-1:0]       retired_pc
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [XLEN-1:0]       instret
`endif
);

    wb_state_e             state_q, state_d;
    mem_wb_t               mw_q, mw_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic [XLEN-1:0]       ext_result;

    load_extender #(
        .XLEN(XLEN)
    ) u_load_extender (
        .raw_data   (mem_load_data),
        .offset     (mem_alu_data[2:0]),
        .size       (load_size_e'(mem_load_size)),
        .is_unsigned(mem_load_unsigned),
        .result     (ext_result)
    );

    // Next-state and MEM/WB capture; mem_done is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        mw_d    = mw_q;
        case (state_q)
            WB_IDLE: begin
                if (mem_done) begin
                    mw_d.pc        = mem_pc;
                    mw_d.wdata     = mem_is_load ? ext_result : mem_alu_data;
                    mw_d.dest_reg  = mem_dest_reg;
                    mw_d.reg_write = mem_reg_write;
                    state_d        = mem_is_ecall ? WB_ECALL_WAIT : WB_WRITE;
                end
            end
            WB_WRITE: begin
                state_d = WB_IDLE;
            end
            WB_ECALL_WAIT: begin
                if (ecall_done) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // Register-file port: driven from the MEM/WB register while writing,
    // otherwise the last written index/data are held
    always_comb begin
        rf_we      = (state_q == WB_WRITE) && mw_q.reg_write
                     && (mw_q.dest_reg != '0);
        rf_waddr   = rf_we ? mw_q.dest_reg : rf_waddr_q;
        rf_wdata   = rf_we ? mw_q.wdata    : rf_wdata_q;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
    end

    // Status and retirement outputs; an ecall retires in the ecall_done cycle
    always_comb begin
        mem_wb_pipeline_valid = (state_q != WB_IDLE);
        ecall_req             = (state_q == WB_ECALL_WAIT);
        retired               = (state_q == WB_WRITE)
                                || ((state_q == WB_ECALL_WAIT) && ecall_done);
        retired_pc            = mw_q.pc;
    end

    // State registers; reset drops any in-flight instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WB_IDLE;
            mw_q       <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mw_q       <= mw_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [XLEN-1:0] instret_q, instret_d;

    // Retired-instruction counter, wraps naturally at 2^XLEN
    always_comb begin
        instret_d = instret_q + {{(XLEN-1){1'b0}}, retired};
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed load-extension vectors,
// x0 writes, ecall handshake, back-to-back issue, randomized traffic against
// an arithmetic reference model, and asynchronous reset during an ecall.
// Build with +define+WB_RETIRE_COUNT_EN to also check instret.
module tb_writeback_stage;

    localparam int XLEN = 64;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_done;
    logic [XLEN-1:0] mem_pc, mem_alu_data, mem_load_data;
    logic [RAW-1:0]  mem_dest_reg;
    logic            mem_reg_write, mem_is_load, mem_load_unsigned, mem_is_ecall;
    logic [1:0]      mem_load_size;
    logic            ecall_done;
    logic            mem_wb_pipeline_valid, ecall_req, rf_we, retired;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata, retired_pc;
`ifdef WB_RETIRE_COUNT_EN
    logic [XLEN-1:0] instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept by the bench
    logic [RAW-1:0]  last_waddr  = '0;
    logic [XLEN-1:0] last_wdata  = '0;
    logic [XLEN-1:0] exp_instret = '0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                  (clk),
        .reset                (rst_n),
        .mem_done             (mem_done),
        .mem_pc               (mem_pc),
        .mem_alu_data         (mem_alu_data),
        .mem_load_data        (mem_load_data),
        .mem_dest_reg         (mem_dest_reg),
        .mem_reg_write        (mem_reg_write),
        .mem_is_load          (mem_is_load),
        .mem_load_size        (mem_load_size),
        .mem_load_unsigned    (mem_load_unsigned),
        .mem_is_ecall         (mem_is_ecall),
        .ecall_done           (ecall_done),
        .mem_wb_pipeline_valid(mem_wb_pipeline_valid),
        .ecall_req            (ecall_req),
        .rf_we                (rf_we),
        .rf_waddr             (rf_waddr),
        .rf_wdata             (rf_wdata),
        .retired              (retired),
        .retired_pc           (retired_pc)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .instret              (instret)
`endif
    );

    // Reference load result: shift the aligned lane down, mask, sign-fill
    function automatic logic [63:0] model_load(input logic [63:0] raw, input int off,
                                               input int sz, input bit uns);
        int bytes;
        int aligned;
        logic [63:0] lane;
        logic [63:0] mask;
        bytes   = 1 << sz;
        if (bytes == 8) return raw;
        aligned = off - (off % bytes);
        lane    = raw >> (aligned * 8);
        mask    = (64'd1 << (bytes * 8)) - 64'd1;
        lane    = lane & mask;
        if (!uns && lane[bytes*8-1]) lane = lane | ~mask;
        return lane;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [63:0] pc, input logic [63:0] alu,
                               input logic [63:0] ld, input logic [4:0] dest,
                               input logic rw, input logic isld, input logic [1:0] sz,
                               input logic uns, input logic ecall);
        mem_pc            = pc;
        mem_alu_data      = alu;
        mem_load_data     = ld;
        mem_dest_reg      = dest;
        mem_reg_write     = rw;
        mem_is_load       = isld;
        mem_load_size     = sz;
        mem_load_unsigned = uns;
        mem_is_ecall      = ecall;
        mem_done          = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_done = 1'b0; mem_pc = '0; mem_alu_data = '0; mem_load_data = '0;
        mem_dest_reg = '0; mem_reg_write = 1'b0; mem_is_load = 1'b0;
        mem_load_size = 2'd0; mem_load_unsigned = 1'b0; mem_is_ecall = 1'b0;
        ecall_done = 1'b0;
        step(); step();
        n_checks++;
        if ({mem_wb_pipeline_valid, ecall_req, rf_we, retired} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b req=%b we=%b ret=%b, required all 0",
                     mem_wb_pipeline_valid, ecall_req, rf_we, retired);
        end
        n_checks++;
        if ({rf_waddr, rf_wdata, retired_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got waddr=%h wdata=%h pc=%h, required 0",
                     rf_waddr, rf_wdata, retired_pc);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (mem_wb_pipeline_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: valid=%b required 0", mem_wb_pipeline_valid);
        end
`ifdef WB_RETIRE_COUNT_EN
        n_checks++;
        if (instret !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_instret: got %0d required 0", instret);
        end
`endif
        $display("txn reset: done");
    endtask

    task automatic test_load_extension();
        logic [63:0] ld, alu, exp;
        logic [1:0]  sz;
        logic        uns;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin ld = 64'h0000_0000_0000_80FF; alu = 64'h1001; sz = 2'd0; uns = 1'b0; exp = 64'hFFFF_FFFF_FFFF_FF80; end
                1: begin ld = 64'h8765_4321_0000_0000; alu = 64'h2004; sz = 2'd2; uns = 1'b1; exp = 64'h0000_0000_8765_4321; end
                2: begin ld = 64'h8765_4321_0000_0000; alu = 64'h2004; sz = 2'd2; uns = 1'b0; exp = 64'hFFFF_FFFF_8765_4321; end
                3: begin ld = 64'h1122_3344_5566_7788; alu = 64'h3003; sz = 2'd1; uns = 1'b0; exp = 64'h0000_0000_0000_5566; end
                4: begin ld = 64'hF122_3344_5566_7788; alu = 64'h4007; sz = 2'd0; uns = 1'b1; exp = 64'h0000_0000_0000_00F1; end
                default: begin ld = 64'h8000_0000_0000_0001; alu = 64'h5005; sz = 2'd3; uns = 1'b1; exp = 64'h8000_0000_0000_0001; end
            endcase
            drive_instr(64'h100 + 64'(i * 4), alu, ld, 5'd5 + 5'(i), 1'b1, 1'b1, sz, uns, 1'b0);
            step();
            mem_done = 1'b0;
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd5 + 5'(i) || rf_wdata !== exp) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: got we=%b waddr=%0d wdata=%h, required we=1 waddr=%0d wdata=%h",
                         i, rf_we, rf_waddr, rf_wdata, 5 + i, exp);
            end
            n_checks++;
            if (retired !== 1'b1 || retired_pc !== 64'h100 + 64'(i * 4)) begin
                n_fail++;
                $display("FAIL load_retire[%0d]: got ret=%b pc=%h, required ret=1 pc=%h",
                         i, retired, retired_pc, 64'h100 + 64'(i * 4));
            end
            exp_instret++;
            last_waddr = 5'd5 + 5'(i);
            last_wdata = exp;
            step();
            n_checks++;
            if (mem_wb_pipeline_valid !== 1'b0 || retired !== 1'b0) begin
                n_fail++;
                $display("FAIL load_idle[%0d]: got valid=%b ret=%b, required 0 0",
                         i, mem_wb_pipeline_valid, retired);
            end
            $display("txn load %0d: size=%0d addr=%h wdata=%h", i, sz, alu, rf_wdata);
        end
    endtask

    task automatic test_alu_x0();
        drive_instr(64'h200, 64'd42, 64'hDEAD, 5'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        step();
        mem_done = 1'b0;
        n_checks++;
        if (rf_we !== 1'b0 || retired !== 1'b1 || mem_wb_pipeline_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_write: got we=%b ret=%b valid=%b, required 0 1 1",
                     rf_we, retired, mem_wb_pipeline_valid);
        end
        n_checks++;
        if (rf_waddr !== last_waddr || rf_wdata !== last_wdata) begin
            n_fail++;
            $display("FAIL x0_hold: got waddr=%0d wdata=%h, required %0d %h",
                     rf_waddr, rf_wdata, last_waddr, last_wdata);
        end
        exp_instret++;
        step();
        n_checks++;
        if (mem_wb_pipeline_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_valid_len: valid=%b required 0", mem_wb_pipeline_valid);
        end
        $display("txn alu x0: alu=42 retired");
    endtask

    task automatic test_ecall();
        drive_instr(64'h300, 64'h0, 64'h0, 5'd17, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step();
        mem_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                ecall_done = 1'b1;
                #1;
            end
            n_checks++;
            if (ecall_req !== 1'b1 || mem_wb_pipeline_valid !== 1'b1 || rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL ecall_wait[%0d]: got req=%b valid=%b we=%b, required 1 1 0",
                         c, ecall_req, mem_wb_pipeline_valid, rf_we);
            end
            n_checks++;
            if (retired !== (c == 4)) begin
                n_fail++;
                $display("FAIL ecall_retire[%0d]: got %b required %b", c, retired, c == 4);
            end
            if (c < 4) step();
        end
        n_checks++;
        if (retired_pc !== 64'h300) begin
            n_fail++;
            $display("FAIL ecall_pc: got %h required 300", retired_pc);
        end
        exp_instret++;
        step();
        ecall_done = 1'b0;
        n_checks++;
        if (ecall_req !== 1'b0 || mem_wb_pipeline_valid !== 1'b0
            || rf_waddr !== last_waddr || rf_wdata !== last_wdata) begin
            n_fail++;
            $display("FAIL ecall_exit: got req=%b valid=%b waddr=%0d wdata=%h",
                     ecall_req, mem_wb_pipeline_valid, rf_waddr, rf_wdata);
        end
        // Stray ecall_done while idle must not retire anything
        ecall_done = 1'b1;
        #1;
        n_checks++;
        if (retired !== 1'b0) begin
            n_fail++;
            $display("FAIL ecall_done_idle: retired=%b required 0", retired);
        end
        step();
        ecall_done = 1'b0;
`ifdef WB_RETIRE_COUNT_EN
        n_checks++;
        if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL ecall_instret: got %0d required %0d", instret, exp_instret);
        end
`endif
        $display("txn ecall: pc=300 retired after 4 cycles");
    endtask

    task automatic test_back_to_back();
        drive_instr(64'h400, 64'hAAAA, 64'h0, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'hAAAA) begin
            n_fail++;
            $display("FAIL b2b_first: got we=%b waddr=%0d wdata=%h, required 1 3 aaaa",
                     rf_we, rf_waddr, rf_wdata);
        end
        exp_instret++;
        // Completion pulse while occupied: must be ignored
        drive_instr(64'h444, 64'hCCCC, 64'h0, 5'd9, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (mem_wb_pipeline_valid !== 1'b0 || rf_we !== 1'b0 || retired !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ignored: got valid=%b we=%b ret=%b, required 0 0 0",
                     mem_wb_pipeline_valid, rf_we, retired);
        end
        drive_instr(64'h408, 64'hBBBB, 64'h0, 5'd4, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        mem_done = 1'b0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 64'hBBBB || retired_pc !== 64'h408) begin
            n_fail++;
            $display("FAIL b2b_second: got we=%b waddr=%0d wdata=%h pc=%h, required 1 4 bbbb 408",
                     rf_we, rf_waddr, rf_wdata, retired_pc);
        end
        exp_instret++;
        last_waddr = 5'd4;
        last_wdata = 64'hBBBB;
        step();
        $display("txn back_to_back: writes x3 then x4");
    endtask

    task automatic test_random();
        logic [63:0] pc, alu, ld, exp_wdata;
        logic [4:0]  dest;
        logic        rw, isld, uns, exp_we;
        logic [1:0]  sz;
        int          gap;
        for (int i = 0; i < 40; i++) begin
            pc   = {$urandom, $urandom};
            alu  = {$urandom, $urandom};
            ld   = {$urandom, $urandom};
            dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rw   = ($urandom_range(0, 3) != 0);
            isld = $urandom_range(0, 1) == 1;
            uns  = $urandom_range(0, 1) == 1;
            sz   = 2'($urandom_range(0, 3));
            exp_we    = rw && (dest != 5'd0);
            exp_wdata = isld ? model_load(ld, int'(alu[2:0]), int'(sz), uns) : alu;
            drive_instr(pc, alu, ld, dest, rw, isld, sz, uns, 1'b0);
            step();
            mem_done = 1'b0;
            n_checks++;
            if (rf_we !== exp_we || retired !== 1'b1 || retired_pc !== pc) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d]: got we=%b ret=%b pc=%h, required we=%b ret=1 pc=%h",
                         i, rf_we, retired, retired_pc, exp_we, pc);
            end
            if (exp_we) begin
                last_waddr = dest;
                last_wdata = exp_wdata;
            end
            n_checks++;
            if (rf_waddr !== last_waddr || rf_wdata !== last_wdata) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got waddr=%0d wdata=%h, required %0d %h",
                         i, rf_waddr, rf_wdata, last_waddr, last_wdata);
            end
            exp_instret++;
            $display("txn rand %0d: ld=%b sz=%0d uns=%b dest=%0d we=%b wdata=%h",
                     i, isld, sz, uns, dest, rf_we, rf_wdata);
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) step();
        end
`ifdef WB_RETIRE_COUNT_EN
        n_checks++;
        if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL rand_instret: got %0d required %0d", instret, exp_instret);
        end
`endif
    endtask

    task automatic test_reset_mid_ecall();
        drive_instr(64'h500, 64'h0, 64'h0, 5'd8, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step();
        mem_done = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_wb_pipeline_valid, ecall_req, rf_we, retired} !== 4'b0
            || {rf_waddr, rf_wdata, retired_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_ecall: got valid=%b req=%b we=%b ret=%b waddr=%0d wdata=%h pc=%h, required all 0",
                     mem_wb_pipeline_valid, ecall_req, rf_we, retired, rf_waddr, rf_wdata, retired_pc);
        end
        exp_instret = '0;
        last_waddr  = '0;
        last_wdata  = '0;
`ifdef WB_RETIRE_COUNT_EN
        n_checks++;
        if (instret !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_instret: got %0d required 0", instret);
        end
`endif
        step();
        rst_n = 1'b1;
        ecall_done = 1'b1;
        #1;
        n_checks++;
        if (retired !== 1'b0 || ecall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: got ret=%b req=%b, required 0 0", retired, ecall_req);
        end
        step();
        ecall_done = 1'b0;
        drive_instr(64'h600, 64'h77, 64'h0, 5'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        mem_done = 1'b0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 64'h77) begin
            n_fail++;
            $display("FAIL post_reset_write: got we=%b waddr=%0d wdata=%h, required 1 2 77",
                     rf_we, rf_waddr, rf_wdata);
        end
        exp_instret++;
        step();
`ifdef WB_RETIRE_COUNT_EN
        n_checks++;
        if (instret !== exp_instret) begin
            n_fail++;
            $display("FAIL post_reset_instret: got %0d required %0d", instret, exp_instret);
        end
`endif
        $display("txn reset_mid_ecall: instruction dropped, recovery write x2");
    endtask

    initial begin
        test_reset();
        test_load_extension();
        test_alu_x0();
        test_ecall();
        test_back_to_back();
        test_random();
        test_reset_mid_ecall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
